sdram_init_refresh_ctrl: RTL

Sequences the SDRAM power-up initialisation (PRECHARGE ALL, two AUTO REFRESH, LOAD MODE REGISTER) once the 200 µs power-up wait has elapsed. It then schedules periodic AUTO REFRESH commands through a request/grant handshake with the read/write datapath FSM. While it owns the command bus, it drives the SDRAM command, address and bank lines. Otherwise the datapath drives them through an external mux selected by BUS_OWN_o.

---
 rtl/sdram_init_refresh_ctrl_if.sv | 23 ++
 rtl/sdram_init_refresh_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_refresh_ctrl_if.sv
// Command-bus and refresh-handshake bundle between the SDRAM init/refresh
// controller (master) and the surrounding datapath/SDRAM side (slave).
interface sdram_init_refresh_ctrl_if;
   logic        INIT_WAIT_200_i;
   logic        REF_GNT_i;
   logic [3:0]  CMD_o;
   logic [11:0] ADDR_o;
   logic [1:0]  BA_o;
   logic        CKE_o;
   logic        INIT_DONE_o;
   logic        REF_REQ_o;
   logic        BUS_OWN_o;

   modport master (
      input  INIT_WAIT_200_i, REF_GNT_i,
      output CMD_o, ADDR_o, BA_o, CKE_o, INIT_DONE_o, REF_REQ_o, BUS_OWN_o
   );

   modport slave (
      output INIT_WAIT_200_i, REF_GNT_i,
      input  CMD_o, ADDR_o, BA_o, CKE_o, INIT_DONE_o, REF_REQ_o, BUS_OWN_o
   );
endinterface

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up initialisation sequencer and periodic AUTO REFRESH scheduler.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   WAIT200  | CKE low, waiting for the 200 us power-up wait to complete
//   CKE_ON   | CKE raised, one cycle before PRECHARGE ALL
//   PRE      | PRECHARGE ALL cycle
//   PRE_W    | NOP spacing after PRECHARGE (T_RP)
//   REF1     | first init AUTO REFRESH cycle
//   REF1_W   | NOP spacing after REF1 (T_RFC)
//   REF2     | second init AUTO REFRESH cycle
//   REF2_W   | NOP spacing after REF2 (T_RFC)
//   MRS      | LOAD MODE REGISTER cycle
//   MRS_W    | NOP spacing after LOAD MODE (T_MRD)
//   IDLE     | datapath owns the bus, no refresh pending
//   REQ      | refresh pending, REF_REQ_o raised, waiting for grant
//   AREF     | periodic AUTO REFRESH cycle
//   AREF_W   | NOP spacing after AUTO REFRESH (T_RFC), bus still owned
//
// Spacing counters are loaded with T_x-1 on the command cycle and the next
// command fires on the edge after they reach zero, so a T_x of 1 skips the
// _W state entirely.
module sdram_init_refresh_ctrl #(
   parameter int          T_RP       = 2,
   parameter int          T_RFC      = 7,
   parameter int          T_MRD      = 2,
   parameter int          REF_PERIOD = 780,
   parameter logic [11:0] MODE_REG   = 12'h033
) (
   input  logic                          CLK,
   input  logic                          RST,
   sdram_init_refresh_ctrl_if.master     bus
);

   localparam logic [3:0]  CMD_NOP  = 4'b0111;
   localparam logic [3:0]  CMD_PRE  = 4'b0010;
   localparam logic [3:0]  CMD_AREF = 4'b0001;
   localparam logic [3:0]  CMD_LMR  = 4'b0000;
   localparam logic [11:0] ADDR_A10 = 12'h400;

   localparam logic [15:0] TRP_M1  = 16'(T_RP - 1);
   localparam logic [15:0] TRFC_M1 = 16'(T_RFC - 1);
   localparam logic [15:0] TMRD_M1 = 16'(T_MRD - 1);
   localparam logic [15:0] TREF_M1 = 16'(REF_PERIOD - 1);

   typedef enum logic [3:0] {
      S_WAIT200, S_CKE_ON,
      S_PRE,  S_PRE_W,
      S_REF1, S_REF1_W,
      S_REF2, S_REF2_W,
      S_MRS,  S_MRS_W,
      S_IDLE, S_REQ,
      S_AREF, S_AREF_W
   } state_t;

   state_t      state;
   logic [15:0] wait_cnt;
   logic [15:0] ref_tmr;
   logic [2:0]  pend_q;
   logic [2:0]  pend_nxt;
   logic        wait_tc;
   logic        done_evt;
   logic        wrap;
   logic        grant;

   assign wait_tc  = (wait_cnt == 16'd0);
   assign done_evt = ((state == S_MRS) || (state == S_MRS_W)) && wait_tc;
   assign wrap     = bus.INIT_DONE_o && (ref_tmr == 16'd0);
   assign grant    = ((state == S_IDLE) || (state == S_REQ)) &&
                     bus.REF_REQ_o && bus.REF_GNT_i;

   // Pending-refresh arithmetic: a wrap and a grant on the same edge cancel,
   // a wrap at 7 is dropped.
   always_comb begin
      pend_nxt = pend_q;
      if (wrap && !grant) begin
         if (pend_q != 3'd7) pend_nxt = pend_q + 3'd1;
      end else if (grant && !wrap) begin
         pend_nxt = pend_q - 3'd1;
      end
   end

   // Refresh interval down-counter (free-running once init completes) and pending count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ref_tmr <= TREF_M1;
         pend_q  <= 3'd0;
      end else begin
         pend_q <= pend_nxt;
         if (done_evt) begin
            ref_tmr <= TREF_M1;
         end else if (bus.INIT_DONE_o) begin
            ref_tmr <= wrap ? TREF_M1 : ref_tmr - 16'd1;
         end
      end
   end

   // Main sequencer with registered command-bus and handshake outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state           <= S_WAIT200;
         wait_cnt        <= 16'd0;
         bus.CMD_o       <= CMD_NOP;
         bus.ADDR_o      <= 12'h000;
         bus.BA_o        <= 2'b00;
         bus.CKE_o       <= 1'b0;
         bus.INIT_DONE_o <= 1'b0;
         bus.REF_REQ_o   <= 1'b0;
         bus.BUS_OWN_o   <= 1'b1;
      end else begin
         bus.CMD_o  <= CMD_NOP;
         bus.ADDR_o <= 12'h000;
         bus.BA_o   <= 2'b00;
         case (state)
            S_WAIT200: begin
               if (bus.INIT_WAIT_200_i) begin
                  bus.CKE_o <= 1'b1;
                  state     <= S_CKE_ON;
               end
            end
            S_CKE_ON: begin
               bus.CMD_o  <= CMD_PRE;
               bus.ADDR_o <= ADDR_A10;
               wait_cnt   <= TRP_M1;
               state      <= S_PRE;
            end
            S_PRE, S_PRE_W: begin
               if (wait_tc) begin
                  bus.CMD_o <= CMD_AREF;
                  wait_cnt  <= TRFC_M1;
                  state     <= S_REF1;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
                  state    <= S_PRE_W;
               end
            end
            S_REF1, S_REF1_W: begin
               if (wait_tc) begin
                  bus.CMD_o <= CMD_AREF;
                  wait_cnt  <= TRFC_M1;
                  state     <= S_REF2;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
                  state    <= S_REF1_W;
               end
            end
            S_REF2, S_REF2_W: begin
               if (wait_tc) begin
                  bus.CMD_o  <= CMD_LMR;
                  bus.ADDR_o <= MODE_REG;
                  bus.BA_o   <= 2'b00;
                  wait_cnt   <= TMRD_M1;
                  state      <= S_MRS;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
                  state    <= S_REF2_W;
               end
            end
            S_MRS, S_MRS_W: begin
               if (wait_tc) begin
                  bus.INIT_DONE_o <= 1'b1;
                  bus.BUS_OWN_o   <= 1'b0;
                  bus.REF_REQ_o   <= 1'b0;
                  state           <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
                  state    <= S_MRS_W;
               end
            end
            S_IDLE, S_REQ: begin
               if (grant) begin
                  bus.CMD_o     <= CMD_AREF;
                  bus.REF_REQ_o <= 1'b0;
                  bus.BUS_OWN_o <= 1'b1;
                  wait_cnt      <= TRFC_M1;
                  state         <= S_AREF;
               end else begin
                  bus.REF_REQ_o <= (pend_nxt != 3'd0);
                  state         <= (pend_nxt != 3'd0) ? S_REQ : S_IDLE;
               end
            end
            S_AREF, S_AREF_W: begin
               if (wait_tc) begin
                  bus.BUS_OWN_o <= 1'b0;
                  bus.REF_REQ_o <= (pend_nxt != 3'd0);
                  state         <= (pend_nxt != 3'd0) ? S_REQ : S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 16'd1;
                  state    <= S_AREF_W;
               end
            end
            default: state <= S_WAIT200;
         endcase
      end
   end

endmodule
